// File: rtl/onchip_ram_pkg.sv
// rtl/onchip_ram_pkg.sv - shared types and constants for the dual-port on-chip RAM
//
// Purpose: FSM state encoding and the legal read-latency range used by the
// top level and by the per-port read pipeline.
// Ports: none (package).
package onchip_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

endpackage

// File: rtl/onchip_ram_dp_if.sv
// rtl/onchip_ram_dp_if.sv - one memory-mapped slave port of the dual-port RAM
//
// Purpose: groups the request/response signals of a single RAM port.
// Ports (signals):
//   address, chipselect, read, write, byteenable, writedata : master -> slave
//   readdata, readdatavalid, waitrequest                    : slave -> master
interface onchip_ram_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/onchip_ram_rd_pipe.sv
// rtl/onchip_ram_rd_pipe.sv - read return pipeline for one RAM port
//
// Purpose: delays an accepted read by READ_LAT enabled cycles, zeroing the
// data of out-of-range reads, and holds the last returned word.
// Ports:
//   clk, reset : clock, synchronous active-high reset (empties the pipe)
//   ce         : effective clock enable; ce=0 freezes every stage
//   req_i      : read accepted this cycle
//   oor_i      : accepted read addresses a word >= DEPTH
//   word_i     : memory word at the read address (pre-write contents)
//   valid_o    : read data valid pulse
//   data_o     : read data, held while valid_o is low
module onchip_ram_rd_pipe
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              req_i,
  input  logic              oor_i,
  input  logic [DATA_W-1:0] word_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  // Out-of-range latency settings fall back to the nearest legal value.
  localparam int LAT = (READ_LAT >= READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT_MIN;

  logic [LAT-1:0]    valid_q;
  logic [DATA_W-1:0] data_q [LAT];

  // A stage's data only moves when a valid word enters it, so the last
  // stage keeps presenting the previous result between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) data_q[i] <= '0;
    end else if (ce) begin
      valid_q[0] <= req_i;
      if (req_i) data_q[0] <= oor_i ? '0 : word_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/onchip_ram_dp.sv
// rtl/onchip_ram_dp.sv - true dual-port byte-enabled on-chip RAM with zero-fill
//
// Purpose: two independent read/write ports onto one DEPTH x DATA_W array,
// optional zero-fill after reset, sticky out-of-range access flag.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   clken, reset_req   : global enable and freeze request (ce = clken & ~reset_req)
//   s1, s2             : slave ports (address/chipselect/read/write/byteenable/
//                        writedata in; readdata/readdatavalid/waitrequest out)
//   init_done          : zero-fill complete (or disabled)
//   oor_err            : sticky, an access with address >= DEPTH was accepted
module onchip_ram_dp
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 4048,
  parameter int ADDR_W         = 12,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clken,
  input  logic             reset_req,
  onchip_ram_dp_if.slave   s1,
  onchip_ram_dp_if.slave   s2,
  output logic             init_done,
  output logic             oor_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  ram_state_e        state_q;
  logic [IDX_W-1:0]  clr_cnt_q;
  logic              oor_err_q;

  logic ce, wait_w;
  logic acc1, acc2, in1, in2, wr1, wr2, rd1, rd2;
  logic [IDX_W-1:0]  idx1, idx2;
  logic [DATA_W-1:0] word1, word2;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              rvalid1, rvalid2;

  assign ce     = clken & ~reset_req;
  assign wait_w = (state_q == ST_CLEAR) | ~ce;

  // Reset wins over any request presented in the same cycle.
  assign acc1 = s1.chipselect & (s1.read | s1.write) & ~wait_w & ~reset;
  assign acc2 = s2.chipselect & (s2.read | s2.write) & ~wait_w & ~reset;

  // Range check uses the full address so nothing above DEPTH can alias.
  assign in1 = ({1'b0, s1.address} < DEPTH_X);
  assign in2 = ({1'b0, s2.address} < DEPTH_X);

  assign idx1 = s1.address[IDX_W-1:0];
  assign idx2 = s2.address[IDX_W-1:0];

  // read+write together is a write only.
  assign wr1 = acc1 & s1.write & in1;
  assign wr2 = acc2 & s2.write & in2;
  assign rd1 = acc1 & ~s1.write;
  assign rd2 = acc2 & ~s2.write;

  assign word1 = mem[idx1];
  assign word2 = mem[idx2];

  // Storage. s1 lanes are assigned after s2 lanes so that, when both
  // ports write one address, s1 owns every lane it enables.
  always_ff @(posedge clk) begin
    if (ce && !reset) begin
      if (state_q == ST_CLEAR) begin
        mem[clr_cnt_q] <= '0;
      end else begin
        for (int b = 0; b < NB; b++) begin
          if (wr2 && s2.byteenable[b]) mem[idx2][8*b +: 8] <= s2.writedata[8*b +: 8];
          if (wr1 && s1.byteenable[b]) mem[idx1][8*b +: 8] <= s1.writedata[8*b +: 8];
        end
      end
    end
  end

  // Control FSM, clear counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
      oor_err_q <= 1'b0;
    end else if (ce) begin
      if (state_q == ST_CLEAR) begin
        if (clr_cnt_q == LAST_IDX) state_q <= ST_READY;
        clr_cnt_q <= clr_cnt_q + IDX_W'(1);
      end
      if ((acc1 && !in1) || (acc2 && !in2)) oor_err_q <= 1'b1;
    end
  end

  onchip_ram_rd_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_rd_pipe_s1 (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .req_i   (rd1),
    .oor_i   (~in1),
    .word_i  (word1),
    .valid_o (rvalid1),
    .data_o  (rdata1)
  );

  onchip_ram_rd_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_rd_pipe_s2 (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .req_i   (rd2),
    .oor_i   (~in2),
    .word_i  (word2),
    .valid_o (rvalid2),
    .data_o  (rdata2)
  );

  assign s1.readdata      = rdata1;
  assign s1.readdatavalid = rvalid1;
  assign s1.waitrequest   = wait_w;
  assign s2.readdata      = rdata2;
  assign s2.readdatavalid = rvalid2;
  assign s2.waitrequest   = wait_w;

  assign init_done = (state_q == ST_READY);
  assign oor_err   = oor_err_q;

endmodule

// File: tb/tb_onchip_ram_dp.sv
// tb/tb_onchip_ram_dp.sv - scoreboard bench for onchip_ram_dp (two configurations)
module tb_onchip_ram_dp;

  localparam int DEPTH_A = 4048;
  localparam int LAT_A   = 1;
  localparam int DEPTH_B = 16;
  localparam int LAT_B   = 2;

  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_WR   = 2'd2;
  localparam logic [1:0] OP_RW   = 2'd3;

  typedef struct packed {
    logic [1:0]  op;
    logic [11:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] e;
  } op_t;

  typedef struct {
    logic [31:0] data;
    int          cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, clken, reset_req;
  logic init_a, init_b, oor_a, oor_b;
  op_t  cur [2];

  exp_t q [4][$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ce_cnt = 0;
  bit   edge_act = 1'b0;
  bit   no_b = 1'b0;
  logic        prev_v [4];
  logic [31:0] prev_d [4];

  onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(12)) a1 ();
  onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(12)) a2 ();
  onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(12)) b1 ();
  onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(12)) b2 ();

  assign a1.address = cur[0].a; assign a1.chipselect = (cur[0].op != OP_IDLE);
  assign a1.read = cur[0].op[0]; assign a1.write = cur[0].op[1];
  assign a1.byteenable = cur[0].be; assign a1.writedata = cur[0].d;
  assign a2.address = cur[1].a; assign a2.chipselect = (cur[1].op != OP_IDLE);
  assign a2.read = cur[1].op[0]; assign a2.write = cur[1].op[1];
  assign a2.byteenable = cur[1].be; assign a2.writedata = cur[1].d;
  assign b1.address = cur[0].a; assign b1.chipselect = (cur[0].op != OP_IDLE);
  assign b1.read = cur[0].op[0]; assign b1.write = cur[0].op[1];
  assign b1.byteenable = cur[0].be; assign b1.writedata = cur[0].d;
  assign b2.address = cur[1].a; assign b2.chipselect = (cur[1].op != OP_IDLE);
  assign b2.read = cur[1].op[0]; assign b2.write = cur[1].op[1];
  assign b2.byteenable = cur[1].be; assign b2.writedata = cur[1].d;

  onchip_ram_dp #(.DATA_W(32), .DEPTH(DEPTH_A), .ADDR_W(12), .READ_LAT(LAT_A),
                  .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1(a1), .s2(a2), .init_done(init_a), .oor_err(oor_a));

  onchip_ram_dp #(.DATA_W(32), .DEPTH(DEPTH_B), .ADDR_W(12), .READ_LAT(LAT_B),
                  .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1(b1), .s2(b2), .init_done(init_b), .oor_err(oor_b));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  function automatic op_t mk(input logic [1:0] op, input int a, input logic [3:0] be,
                             input logic [31:0] d, input logic [31:0] e);
    op_t p;
    p.op = op; p.a = a[11:0]; p.be = be; p.d = d; p.e = e;
    return p;
  endfunction

  // Hand-derived final contents after the directed writes (all else zero).
  function automatic logic [31:0] final_word(input int a);
    case (a)
      3:       return 32'h22222211;
      5:       return 32'hFFFFBEEF;
      6:       return 32'h55555555;
      7:       return 32'h0BADF00D;
      default: return 32'h00000000;
    endcase
  endfunction

  task automatic push(input int k, input op_t p);
    exp_t x;
    x.data = p.e;
    x.cnt  = ce_cnt + LAT_A;
    q[k].push_back(x);
    if (!no_b) begin
      x.data = (p.a < DEPTH_B) ? p.e : 32'h0;
      x.cnt  = ce_cnt + LAT_B;
      q[2+k].push_back(x);
    end
  endtask

  task automatic cycle(input op_t p1, input op_t p2, input bit ck, input bit rr);
    cur[0] = p1; cur[1] = p2; clken = ck; reset_req = rr;
    if (ck && !rr && !reset) begin
      if (p1.op == OP_RD) push(0, p1);
      if (p2.op == OP_RD) push(1, p2);
    end
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    edge_act = (clken & ~reset_req) | reset;
    if (clken && !reset_req) ce_cnt++;
  end

  task automatic mon(input int k, input logic v, input logic [31:0] d);
    exp_t x;
    if (!edge_act) begin
      check($sformatf("hold_valid_p%0d", k), 32'(v), 32'(prev_v[k]));
      check($sformatf("hold_data_p%0d", k), d, prev_d[k]);
    end else if (v) begin
      if (q[k].size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid_p%0d: got valid with data 0x%08h, required no valid", k, d);
      end else begin
        x = q[k].pop_front();
        check($sformatf("rdata_p%0d", k), d, x.data);
        check($sformatf("latency_p%0d", k), ce_cnt, x.cnt);
      end
    end
    prev_v[k] = v;
    prev_d[k] = d;
  endtask

  always @(negedge clk) begin
    mon(0, a1.readdatavalid, a1.readdata);
    mon(1, a2.readdatavalid, a2.readdata);
    mon(2, b1.readdatavalid, b1.readdata);
    mon(3, b2.readdatavalid, b2.readdata);
  end

  task automatic wait_init(output int cnt_a, output int cnt_b);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 6000; i++) begin
      #1;
      if (a1.waitrequest) cnt_a++;
      if (b1.waitrequest) cnt_b++;
      if (init_a && init_b) break;
      @(negedge clk);
    end
    check("init_done_a", 32'(init_a), 32'd1);
    check("init_done_b", 32'(init_b), 32'd1);
  endtask

  initial begin
    #500000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    op_t idle;
    int  ca, cb;
    idle = '0;
    cur[0] = '0; cur[1] = '0;
    reset = 1'b1; clken = 1'b0; reset_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset applied with clken low
    check("rst_init_a", 32'(init_a), 32'd0);
    check("rst_init_b", 32'(init_b), 32'd0);
    check("rst_rdv_a1", 32'(a1.readdatavalid), 32'd0);
    check("rst_rdata_a1", a1.readdata, 32'h0);
    check("rst_rdv_b2", 32'(b2.readdatavalid), 32'd0);
    check("rst_rdata_b2", b2.readdata, 32'h0);
    check("rst_oor_a", 32'(oor_a), 32'd0);
    check("rst_oor_b", 32'(oor_b), 32'd0);

    reset = 1'b0; clken = 1'b1;
    wait_init(ca, cb);
    check("clear_wait_cycles_b", cb, DEPTH_B);
    check("clear_wait_cycles_a", ca, DEPTH_A);
    check("ready_wait_b", 32'(b2.waitrequest), 32'd0);

    // Zero-filled contents
    for (int i = 0; i < 16; i++) cycle(mk(OP_RD, i, 4'h0, 32'h0, 32'h0), idle, 1'b1, 1'b0);

    // Partial byte write then read from the other port
    cycle(mk(OP_WR, 5, 4'hF, 32'hFFFFFFFF, 32'h0), idle, 1'b1, 1'b0);
    cycle(mk(OP_WR, 5, 4'h3, 32'hDEADBEEF, 32'h0), idle, 1'b1, 1'b0);
    cycle(idle, mk(OP_RD, 5, 4'h0, 32'h0, 32'hFFFFBEEF), 1'b1, 1'b0);

    // Same-cycle read of a word being written returns old data
    cycle(mk(OP_WR, 6, 4'hF, 32'hAAAAAAAA, 32'h0), idle, 1'b1, 1'b0);
    cycle(mk(OP_WR, 6, 4'hF, 32'h55555555, 32'h0), mk(OP_RD, 6, 4'h0, 32'h0, 32'hAAAAAAAA), 1'b1, 1'b0);
    cycle(mk(OP_RD, 6, 4'h0, 32'h0, 32'h55555555), idle, 1'b1, 1'b0);

    // read+write together acts as a write only (no read data returned)
    cycle(mk(OP_RW, 7, 4'hF, 32'h0BADF00D, 32'h0), idle, 1'b1, 1'b0);
    cycle(idle, mk(OP_RD, 7, 4'h0, 32'h0, 32'h0BADF00D), 1'b1, 1'b0);

    // Dual-port write collision
    cycle(mk(OP_WR, 3, 4'hF, 32'h11111111, 32'h0), mk(OP_WR, 3, 4'hF, 32'h22222222, 32'h0), 1'b1, 1'b0);
    cycle(mk(OP_RD, 3, 4'h0, 32'h0, 32'h11111111), idle, 1'b1, 1'b0);
    cycle(mk(OP_WR, 3, 4'h1, 32'h11111111, 32'h0), mk(OP_WR, 3, 4'hF, 32'h22222222, 32'h0), 1'b1, 1'b0);
    cycle(idle, mk(OP_RD, 3, 4'h0, 32'h0, 32'h22222211), 1'b1, 1'b0);

    // Out-of-range read and write
    check("oor_a_before", 32'(oor_a), 32'd0);
    check("oor_b_before", 32'(oor_b), 32'd0);
    cycle(mk(OP_RD, 4048, 4'h0, 32'h0, 32'h0), mk(OP_WR, 4050, 4'hF, 32'hCAFEF00D, 32'h0), 1'b1, 1'b0);
    check("oor_a_after", 32'(oor_a), 32'd1);
    check("oor_b_after", 32'(oor_b), 32'd1);
    for (int i = 0; i < DEPTH_A; i++)
      cycle(mk(OP_RD, i, 4'h0, 32'h0, final_word(i)), idle, 1'b1, 1'b0);

    // Back-to-back reads with a two-cycle clken freeze mid-stream
    cycle(mk(OP_RD, 3, 4'h0, 32'h0, 32'h22222211), idle, 1'b1, 1'b0);
    cycle(mk(OP_RD, 5, 4'h0, 32'h0, 32'hFFFFBEEF), idle, 1'b1, 1'b0);
    cycle(mk(OP_RD, 6, 4'h0, 32'h0, 32'h55555555), idle, 1'b0, 1'b0);
    cycle(mk(OP_RD, 6, 4'h0, 32'h0, 32'h55555555), idle, 1'b0, 1'b0);
    cycle(mk(OP_RD, 6, 4'h0, 32'h0, 32'h55555555), idle, 1'b1, 1'b0);
    cycle(mk(OP_RD, 0, 4'h0, 32'h0, 32'h0), idle, 1'b1, 1'b0);

    // Freeze via reset_req
    cycle(idle, mk(OP_RD, 7, 4'h0, 32'h0, 32'h0BADF00D), 1'b1, 1'b1);
    cycle(idle, mk(OP_RD, 7, 4'h0, 32'h0, 32'h0BADF00D), 1'b1, 1'b0);
    repeat (4) cycle(idle, idle, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) check($sformatf("queue_drained_p%0d", k), q[k].size(), 0);

    // Reset one cycle after an accepted read: latency-2 read is discarded
    no_b = 1'b1;
    cycle(mk(OP_RD, 5, 4'h0, 32'h0, 32'hFFFFBEEF), idle, 1'b1, 1'b0);
    no_b = 1'b0;
    reset = 1'b1;
    cycle(idle, idle, 1'b1, 1'b0);
    check("rst2_rdv_b1", 32'(b1.readdatavalid), 32'd0);
    check("rst2_rdata_b1", b1.readdata, 32'h0);
    check("rst2_rdv_a1", 32'(a1.readdatavalid), 32'd0);
    check("rst2_rdata_a1", a1.readdata, 32'h0);
    check("rst2_oor_a", 32'(oor_a), 32'd0);
    check("rst2_init_b", 32'(init_b), 32'd0);
    reset = 1'b0;
    wait_init(ca, cb);
    check("reclear_wait_cycles_b", cb, DEPTH_B);
    repeat (4) cycle(idle, idle, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) check($sformatf("queue_final_p%0d", k), q[k].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/onchip_ram_dp.md
ONCHIP_RAM_DP -- requirements
Module: onchip_ram_dp

Interface
REQ-001 Parameter DATA_W, 32, data width in bits; multiple of 8.
REQ-002 Parameter DEPTH, 4048, number of words; need not be a power of two.
REQ-003 Parameter ADDR_W, 12, address width; 2**ADDR_W >= DEPTH.
REQ-004 Parameter READ_LAT, 1, read latency in enabled cycles; legal values 1 or 2.
REQ-005 Parameter CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 clken  in  1  global clock enable.
REQ-009 reset_req  in  1  freeze request; effective enable ce = clken & ~reset_req.
REQ-010 s1_/s2_ port group, one per port: address in ADDR_W; chipselect in 1; read in 1; write in 1; byteenable in DATA_W/8; writedata in DATA_W.
REQ-011 s1_/s2_ outputs per port: readdata out DATA_W; readdatavalid out 1; waitrequest out 1.
REQ-012 init_done  out  1  high when the zero-fill is complete or disabled.
REQ-013 oor_err  out  1  sticky flag: an access with address >= DEPTH was accepted.

Function
REQ-014 FSM states CLEAR and READY; reset enters CLEAR with clear counter 0 if CLEAR_ON_RESET=1, else READY.
REQ-015 In CLEAR, each cycle with ce=1 writes all-zero to word[counter] and increments counter; the cycle after counter=DEPTH-1, state becomes READY (exactly DEPTH enabled cycles).
REQ-016 waitrequest (both ports) = (state==CLEAR) | ~ce; init_done = (state==READY).
REQ-017 Accept per port = chipselect & (read|write) & ~waitrequest; read and write both high is treated as write only.
REQ-018 Accepted write updates only the byte lanes with byteenable=1, visible to reads accepted from the next cycle on.
REQ-019 Accepted read: readdatavalid pulses high exactly READ_LAT ce-cycles after accept; back-to-back reads return one word per cycle, in order.
REQ-020 ce=0 freezes memory, FSM, counter, read pipeline, and outputs; no cycle is counted toward latency.
REQ-021 readdata holds its last value while readdatavalid is low.
REQ-022 Read and write to the same address in the same cycle (same or other port): read returns old data.
REQ-023 Both ports writing the same address in one cycle: lanes enabled on both take s1 data; lanes enabled only on s2 take s2 data.
REQ-024 Address >= DEPTH: write dropped; read completes with normal latency and readdata=0; oor_err set next cycle.
REQ-025 Address decode never aliases: no out-of-range access touches any word.

Reset
REQ-026 On reset: readdata=0, readdatavalid=0, oor_err=0, read pipeline emptied; in-flight reads are discarded without a valid pulse.
REQ-027 waitrequest=1 and init_done=0 during and after reset while in CLEAR; with CLEAR_ON_RESET=0, init_done=1 the first cycle after reset.
REQ-028 Memory contents survive reset when CLEAR_ON_RESET=0; reset mid-CLEAR restarts the clear from word 0.
REQ-029 Reset overrides ce: applied even when clken=0.

Structure
REQ-030 Package onchip_ram_pkg holds the state enum (CLEAR, READY) and the legal READ_LAT constants.
REQ-031 One sub-module onchip_ram_rd_pipe (valid/data shift stage, depth READ_LAT, with out-of-range zeroing), instantiated once per port.
REQ-032 Storage is an inferable true-dual-port byte-enabled array; no vendor primitive instantiation.

Verification
REQ-033 Reset, CLEAR_ON_RESET=1, DEPTH=16 -> waitrequest high 16 cycles, init_done rises cycle 17, all reads return 0x00000000.
REQ-034 s1 write 0xDEADBEEF to addr 5, byteenable 0b0011, over 0xFFFFFFFF -> s2 read addr 5 returns 0xFFFFBEEF, valid READ_LAT cycles later (run for 1 and 2).
REQ-035 Same cycle: s1 write 0x11111111 be 0b1111, s2 write 0x22222222 be 0b1111 to addr 3 -> read returns 0x11111111; repeat with s1 be 0b0001 -> 0x22222211.
REQ-036 s1 read addr 4048 and s2 write addr 4050 (DEPTH=4048) -> readdata 0, valid on time, oor_err=1, words 0..4047 unchanged.
REQ-037 Four back-to-back reads with clken low for 2 cycles mid-stream -> four valid pulses in order, stretched by exactly 2 cycles.
REQ-038 Reset asserted 1 cycle after a read is accepted -> no readdatavalid pulse, readdata=0.
